// File: rtl/survivor_writer_pkg.sv
// Shared widths and FSM encodings for the Viterbi survivor-memory writer.
// SW_PARITY_EN widens the RAM word by one parity bit.
package survivor_writer_pkg;

  localparam int N_ACS       = 4;
  localparam int WD_RAM_DATA = 8;
  localparam int WD_STATE    = 8;
  localparam int WD_FSM      = 6;
  localparam int WD_RAM_ADDR = 11;
  localparam int TB_INTERVAL = 8;

  localparam int BEATS  = WD_RAM_DATA / N_ACS;
  localparam int WORDS  = (2 ** WD_STATE) / WD_RAM_DATA;
  localparam int SW     = WD_RAM_ADDR - WD_FSM;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef SW_PARITY_EN
  localparam int RD_W = WD_RAM_DATA + 1;
`else
  localparam int RD_W = WD_RAM_DATA;
`endif

  typedef enum logic [1:0] {
    S_BOUND = 2'd0,
    S_FILL  = 2'd1,
    S_STALL = 2'd2
  } sw_state_e;

endpackage

// File: rtl/survivor_writer_packer.sv
// sw_packer: gathers N_ACS-bit decision beats into RAM words, zero-pads short words,
// registers the finished word for the write port (optional parity under SW_PARITY_EN).
module sw_packer
  import survivor_writer_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              flush,
  input  logic              beat_vld,
  input  logic              beat_close,
  input  logic [N_ACS-1:0]  beat_bits,
  output logic [BEAT_W-1:0] beat,
  output logic              wr_vld_p1,
  output logic [RD_W-1:0]   wr_data_p1
);

  logic [WD_RAM_DATA-1:0] acc_p0;
  logic [WD_RAM_DATA-1:0] word_n;
  logic                   last_beat;
  logic                   word_done;

`ifdef SW_PARITY_EN
  function automatic logic even_parity(input logic [WD_RAM_DATA-1:0] d);
    return ^d;
  endfunction

  function automatic logic [RD_W-1:0] pack_word(input logic [WD_RAM_DATA-1:0] d);
    return {even_parity(d), d};
  endfunction
`else
  function automatic logic [RD_W-1:0] pack_word(input logic [WD_RAM_DATA-1:0] d);
    return d;
  endfunction
`endif

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign word_done = beat_vld & (last_beat | beat_close);

  // acc_p0 is cleared after every word, so unfilled slices are already the zero padding
  always_comb begin
    word_n = acc_p0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat == BEAT_W'(k)) word_n[k*N_ACS +: N_ACS] = beat_bits;
    end
  end

  // p0 -> p1: finished word registered onto the RAM write port
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc_p0     <= '0;
      beat       <= '0;
      wr_vld_p1  <= 1'b0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= word_done;
      if (flush) begin
        acc_p0 <= '0;
        beat   <= '0;
      end else if (word_done) begin
        acc_p0     <= '0;
        beat       <= '0;
        wr_data_p1 <= pack_word(word_n);
      end else if (beat_vld) begin
        acc_p0 <= word_n;
        beat   <= beat + 1'b1;
      end
    end
  end

endmodule

// File: rtl/survivor_writer.sv
// Survivor-memory write side: stage/word addressing, traceback lock stall, TbStart pacing.
// Optional SW_PARITY_EN appends an even-parity bit to each RAM word.
module survivor_writer
  import survivor_writer_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Flush,
  input  logic                   DecValid,
  output logic                   DecReady,
  input  logic [N_ACS-1:0]       DecBits,
  input  logic                   DecLast,
  output logic                   RamWrEn,
  output logic [WD_RAM_ADDR-1:0] RamWrAddr,
  output logic [RD_W-1:0]        RamWrData,
  input  logic                   TbBusy,
  input  logic [SW-1:0]          TbLockStage,
  output logic                   TbStart,
  output logic [SW-1:0]          TbStage,
  output logic                   ErrFrame
);

  localparam logic [SW-1:0] TB_MASK = SW'(TB_INTERVAL - 1);

  sw_state_e         state, state_n;
  logic [SW-1:0]     stage;
  logic [WD_FSM-1:0] word_idx;
  logic [BEAT_W-1:0] beat;
  logic              ready_c;
  logic              locked;
  logic              accept;
  logic              last_beat;
  logic              at_final;
  logic              close;
  logic              misalign;
  logic              tb_due;

  assign locked    = TbBusy && (stage == TbLockStage);
  assign DecReady  = ready_c & ~Flush & Reset;
  assign accept    = DecValid & DecReady;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign at_final  = (word_idx == WD_FSM'(WORDS - 1)) && last_beat;
  // a stage closes on DecLast or is force-closed once the full word count is reached
  assign close     = DecLast | at_final;
  assign misalign  = DecLast ^ at_final;
  assign tb_due    = ((stage + 1'b1) & TB_MASK) == '0;

  always_comb begin
    state_n = state;
    ready_c = 1'b0;
    case (state)
      S_BOUND: begin
        if (locked) begin
          state_n = S_STALL;
        end else begin
          ready_c = 1'b1;
          if (DecValid && !close) state_n = S_FILL;
        end
      end
      S_FILL: begin
        ready_c = 1'b1;
        if (DecValid && close) state_n = S_BOUND;
      end
      S_STALL: begin
        if (!locked) state_n = S_BOUND;
      end
      default: state_n = S_BOUND;
    endcase
  end

  sw_packer u_packer (
    .Clock      (Clock),
    .Reset      (Reset),
    .flush      (Flush),
    .beat_vld   (accept),
    .beat_close (close),
    .beat_bits  (DecBits),
    .beat       (beat),
    .wr_vld_p1  (RamWrEn),
    .wr_data_p1 (RamWrData)
  );

  // p0 -> p1: address and traceback pulse registered alongside the packer's write word
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_BOUND;
      stage     <= '0;
      word_idx  <= '0;
      RamWrAddr <= '0;
      TbStart   <= 1'b0;
      TbStage   <= '0;
      ErrFrame  <= 1'b0;
    end else if (Flush) begin
      state    <= S_BOUND;
      stage    <= '0;
      word_idx <= '0;
      TbStart  <= 1'b0;
      ErrFrame <= 1'b0;
    end else begin
      state   <= state_n;
      TbStart <= accept & close & tb_due;
      if (accept) begin
        if (last_beat || close) RamWrAddr <= {stage, word_idx};
        if (misalign) ErrFrame <= 1'b1;
        if (close) begin
          stage    <= stage + 1'b1;
          word_idx <= '0;
          if (tb_due) TbStage <= stage;
        end else if (last_beat) begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_survivor_writer.sv
// Self-checking bench for survivor_writer: stage-buffer reference model plus write scoreboard.
module tb_survivor_writer;

`ifdef SW_PARITY_EN
  localparam int DW = 9;
`else
  localparam int DW = 8;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          Flush = 1'b0;
  logic          DecValid = 1'b0;
  logic          DecReady;
  logic [3:0]    DecBits = 4'h0;
  logic          DecLast = 1'b0;
  logic          RamWrEn;
  logic [10:0]   RamWrAddr;
  logic [DW-1:0] RamWrData;
  logic          TbBusy = 1'b0;
  logic [4:0]    TbLockStage = 5'd0;
  logic          TbStart;
  logic [4:0]    TbStage;
  logic          ErrFrame;

  survivor_writer dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .DecValid(DecValid), .DecReady(DecReady),
    .DecBits(DecBits), .DecLast(DecLast), .RamWrEn(RamWrEn), .RamWrAddr(RamWrAddr),
    .RamWrData(RamWrData), .TbBusy(TbBusy), .TbLockStage(TbLockStage), .TbStart(TbStart),
    .TbStage(TbStage), .ErrFrame(ErrFrame)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [10:0]   addr;
    logic [DW-1:0] data;
    logic          tbs;
    logic [4:0]    tbstg;
  } wr_t;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int tbs_count = 0;
  logic [10:0] last_tbs_addr = '0;
  logic [4:0]  last_tbstg = '0;

  wr_t exp_q[$];
  wr_t act_q[$];
  logic [3:0] sbuf[$];
  int m_stage = 0;
  bit m_err = 0;

  function automatic logic [DW-1:0] make_data(input logic [7:0] d);
`ifdef SW_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // A stage is a list of beats; word w of stage s holds beats 2w,2w+1 at address s*64+w.
  function automatic void model_beat(input logic [3:0] b, input logic l);
    int n, w;
    bit cl;
    logic [7:0] d;
    wr_t e;
    sbuf.push_back(b);
    n  = sbuf.size();
    cl = l || (n == 64);
    if (cl && ((l == 1'b1) != (n == 64))) m_err = 1;
    if ((n % 2 == 0) || cl) begin
      w = (n - 1) / 2;
      d = {((n % 2 == 0) ? sbuf[2*w+1] : 4'h0), sbuf[2*w]};
      e.addr  = 11'(m_stage * 64 + w);
      e.data  = make_data(d);
      e.tbs   = cl && ((m_stage + 1) % 8 == 0);
      e.tbstg = 5'(m_stage);
      exp_q.push_back(e);
    end
    if (cl) begin
      m_stage = (m_stage + 1) % 32;
      sbuf.delete();
    end
  endfunction

  function automatic void model_flush();
    sbuf.delete();
    m_stage = 0;
    m_err = 0;
  endfunction

  always @(negedge Clock) begin
    wr_t a, e;
    if (RamWrEn) begin
      a.addr = RamWrAddr; a.data = RamWrData; a.tbs = TbStart; a.tbstg = TbStage;
      act_q.push_back(a);
      wr_count++;
    end
    if (TbStart) begin
      tbs_count++;
      last_tbs_addr = RamWrAddr;
      last_tbstg = TbStage;
      checks++;
      if (!RamWrEn) begin
        errors++;
        $display("FAIL tbstart_without_write: RamWrEn=%0b required 1", RamWrEn);
      end
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.tbs !== e.tbs ||
          (e.tbs && a.tbstg !== e.tbstg)) begin
        errors++;
        $display("FAIL write: got addr=%h data=%h tbs=%0b tbstg=%0d, required addr=%h data=%h tbs=%0b tbstg=%0d",
                 a.addr, a.data, a.tbs, a.tbstg, e.addr, e.data, e.tbs, e.tbstg);
      end
    end
  end

  task automatic send_beat(input logic [3:0] b, input logic l);
    int guard = 0;
    DecValid = 1'b1; DecBits = b; DecLast = l;
    #1;
    while (!DecReady && guard < 64) begin
      @(negedge Clock); #1;
      guard++;
    end
    if (guard >= 64) begin
      checks++; errors++;
      $display("FAIL ready_timeout: DecReady=%0b required 1 within 64 cycles", DecReady);
    end else begin
      model_beat(b, l);
    end
    @(negedge Clock);
    DecValid = 1'b0; DecLast = 1'b0;
  endtask

  task automatic run_stage(input int n, input bit with_last, input logic [3:0] fixed, input bit rnd);
    for (int i = 0; i < n; i++)
      send_beat(rnd ? 4'($urandom) : fixed, with_last && (i == n - 1));
  endtask

  task automatic do_flush();
    Flush = 1'b1;
    @(negedge Clock);
    Flush = 1'b0;
    model_flush();
  endtask

  task automatic wait_drain(input string name);
    repeat (3) @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0 || act_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending expected=%0d actual=%0d required 0/0", name, exp_q.size(), act_q.size());
      exp_q.delete(); act_q.delete();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checks += 7;
    if (RamWrEn !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b required 0", RamWrEn); end
    if (RamWrAddr !== '0) begin errors++; $display("FAIL rst_addr: got %h required 0", RamWrAddr); end
    if (RamWrData !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", RamWrData); end
    if (TbStart !== 1'b0) begin errors++; $display("FAIL rst_tbstart: got %b required 0", TbStart); end
    if (TbStage !== '0) begin errors++; $display("FAIL rst_tbstage: got %h required 0", TbStage); end
    if (ErrFrame !== 1'b0) begin errors++; $display("FAIL rst_errframe: got %b required 0", ErrFrame); end
    if (DecReady !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", DecReady); end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (DecReady !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b required 1", DecReady); end
    model_flush();
  endtask

  task automatic test_single_stage();
    int w0 = wr_count;
    send_beat(4'hA, 1'b0);
    checks++;
    if (RamWrEn !== 1'b0) begin errors++; $display("FAIL early_write: RamWrEn=%b required 0", RamWrEn); end
    send_beat(4'hA, 1'b0);
    checks++;
    if (RamWrEn !== 1'b1 || RamWrAddr !== 11'd0) begin
      errors++; $display("FAIL write_latency: RamWrEn=%b addr=%h required 1/000", RamWrEn, RamWrAddr);
    end
    run_stage(62, 1'b1, 4'hA, 1'b0);
    wait_drain("single");
    checks += 2;
    if (wr_count - w0 !== 32) begin errors++; $display("FAIL single_count: got %0d writes required 32", wr_count - w0); end
    if (ErrFrame !== 1'b0) begin errors++; $display("FAIL single_err: got %b required 0", ErrFrame); end
  endtask

  task automatic test_tb_start();
    int t0 = tbs_count;
    for (int s = 0; s < 8; s++) run_stage(64, 1'b1, 4'h0, 1'b1);
    wait_drain("tbstart");
    checks += 3;
    if (tbs_count - t0 !== 1) begin errors++; $display("FAIL tbstart_count: got %0d required 1", tbs_count - t0); end
    if (last_tbs_addr !== {5'd7, 6'd31}) begin errors++; $display("FAIL tbstart_addr: got %h required %h", last_tbs_addr, {5'd7, 6'd31}); end
    if (last_tbstg !== 5'd7) begin errors++; $display("FAIL tbstart_stage: got %0d required 7", last_tbstg); end
  endtask

  task automatic test_lock_stall();
    int w0;
    do_flush();
    run_stage(64, 1'b1, 4'h0, 1'b1);
    run_stage(64, 1'b1, 4'h0, 1'b1);
    TbBusy = 1'b1; TbLockStage = 5'd2;
    DecValid = 1'b1; DecBits = 4'h5;
    @(negedge Clock);
    w0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      checks++;
      if (DecReady !== 1'b0 || RamWrEn !== 1'b0) begin
        errors++; $display("FAIL lock_stall: DecReady=%b RamWrEn=%b required 0/0", DecReady, RamWrEn);
      end
    end
    checks++;
    if (wr_count !== w0) begin errors++; $display("FAIL lock_nowrite: got %0d writes required 0", wr_count - w0); end
    DecValid = 1'b0; TbBusy = 1'b0;
    run_stage(10, 1'b0, 4'h0, 1'b1);
    TbBusy = 1'b1;
    DecValid = 1'b1;
    #1;
    checks++;
    if (DecReady !== 1'b1) begin errors++; $display("FAIL midstage_lock: DecReady=%b required 1", DecReady); end
    run_stage(54, 1'b1, 4'h0, 1'b1);
    TbLockStage = 5'd5;
    DecValid = 1'b1;
    #1;
    checks++;
    if (DecReady !== 1'b1) begin errors++; $display("FAIL other_stage_lock: DecReady=%b required 1", DecReady); end
    DecValid = 1'b0; TbBusy = 1'b0;
    wait_drain("lock");
  endtask

  task automatic test_early_last();
    send_beat(4'h3, 1'b0);
    send_beat(4'h9, 1'b0);
    send_beat(4'h6, 1'b1);
    checks++;
    if (RamWrEn !== 1'b1 || RamWrData[7:0] !== 8'h06) begin
      errors++; $display("FAIL pad_word: RamWrEn=%b data=%h required 1/06", RamWrEn, RamWrData);
    end
    @(negedge Clock);
    checks++;
    if (ErrFrame !== 1'b1) begin errors++; $display("FAIL early_err: got %b required 1", ErrFrame); end
    run_stage(64, 1'b1, 4'h0, 1'b1);
    checks++;
    if (ErrFrame !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", ErrFrame); end
    do_flush();
    run_stage(64, 1'b0, 4'h0, 1'b1);
    @(negedge Clock);
    checks++;
    if (ErrFrame !== 1'b1) begin errors++; $display("FAIL overrun_err: got %b required 1", ErrFrame); end
    run_stage(4, 1'b0, 4'h0, 1'b1);
    wait_drain("early");
  endtask

  task automatic test_async_reset();
    int w0;
    send_beat(4'h7, 1'b0);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (RamWrEn !== 1'b0 || ErrFrame !== 1'b0 || DecReady !== 1'b0) begin
      errors++; $display("FAIL async_rst: wren=%b err=%b ready=%b required 0/0/0", RamWrEn, ErrFrame, DecReady);
    end
    w0 = wr_count;
    @(negedge Clock);
    Reset = 1'b1;
    model_flush();
    @(negedge Clock);
    checks++;
    if (wr_count !== w0) begin errors++; $display("FAIL async_rst_nowrite: got %0d writes required 0", wr_count - w0); end
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    checks++;
    if (RamWrAddr !== 11'd0 || RamWrData[7:0] !== 8'h21) begin
      errors++; $display("FAIL async_rst_resume: addr=%h data=%h required 000/21", RamWrAddr, RamWrData);
    end
    wait_drain("async");
  endtask

  task automatic test_flush();
    int w0;
    do_flush();
    send_beat(4'hC, 1'b1);
    @(negedge Clock);
    checks++;
    if (ErrFrame !== 1'b1) begin errors++; $display("FAIL flush_pre_err: got %b required 1", ErrFrame); end
    wait_drain("flush_pre");
    send_beat(4'h4, 1'b0);
    Flush = 1'b1; DecValid = 1'b1; DecBits = 4'hF;
    w0 = wr_count;
    @(negedge Clock);
    Flush = 1'b0; DecValid = 1'b0;
    model_flush();
    checks += 2;
    if (RamWrEn !== 1'b0) begin errors++; $display("FAIL flush_nowrite: RamWrEn=%b required 0", RamWrEn); end
    if (ErrFrame !== 1'b0) begin errors++; $display("FAIL flush_err: got %b required 0", ErrFrame); end
    @(negedge Clock);
    checks++;
    if (wr_count !== w0) begin errors++; $display("FAIL flush_dropped: got %0d writes required 0", wr_count - w0); end
    send_beat(4'h8, 1'b0);
    send_beat(4'hB, 1'b0);
    checks++;
    if (RamWrAddr !== 11'd0 || RamWrData[7:0] !== 8'hB8) begin
      errors++; $display("FAIL flush_resume: addr=%h data=%h required 000/b8", RamWrAddr, RamWrData);
    end
    wait_drain("flush");
  endtask

`ifdef SW_PARITY_EN
  task automatic test_parity();
    do_flush();
    send_beat(4'h1, 1'b0);
    send_beat(4'h0, 1'b0);
    checks++;
    if (RamWrData !== 9'h101) begin errors++; $display("FAIL parity: got %h required 101", RamWrData); end
    wait_drain("parity");
  endtask
`endif

  task automatic test_random();
    int n, r;
    do_flush();
    for (int s = 0; s < 12; s++) begin
      r = $urandom_range(0, 7);
      n = (r == 0) ? $urandom_range(1, 63) : 64;
      if ($urandom_range(0, 3) == 0) begin
        TbBusy = 1'b1; TbLockStage = 5'(m_stage);
        DecValid = 1'b1; DecBits = 4'($urandom);
        repeat (2) begin
          @(negedge Clock);
          checks++;
          if (DecReady !== 1'b0) begin errors++; $display("FAIL rand_stall: DecReady=%b required 0", DecReady); end
        end
        DecValid = 1'b0;
      end
      TbBusy = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          TbBusy = 1'($urandom);
          TbLockStage = 5'($urandom);
        end
        if ($urandom_range(0, 3) == 0) @(negedge Clock);
        send_beat(4'($urandom), (r != 1) && (i == n - 1));
      end
    end
    TbBusy = 1'b0;
    wait_drain("random");
    checks++;
    if (ErrFrame !== m_err) begin errors++; $display("FAIL rand_err: got %b required %b", ErrFrame, m_err); end
  endtask

  initial begin
    test_reset();
    test_single_stage();
    test_tb_start();
    test_lock_stall();
    test_early_last();
    test_async_reset();
    test_flush();
`ifdef SW_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
